// File: rtl/apd04_dpsram_init.sv
// apd04_dpsram_init: dual-port SRAM with hardware clear, read-valid tracking, RDW policy and write-collision arbitration
module apd04_dpsram_init #(
  parameter type T = logic [31:0],
  parameter int WORDS = 128,
  parameter bit OUT_REG = 1'b0,
  parameter bit WRITE_FIRST = 1'b0,
  parameter T INIT_VALUE = '1,
  localparam int ADDR_WIDTH = $clog2(WORDS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_req_i,
  output logic                  init_busy_o,
  input  T                      a_din_i,
  input  logic                  a_wen_i,
  input  logic [ADDR_WIDTH-1:0] a_waddr_i,
  input  logic                  a_ren_i,
  input  logic [ADDR_WIDTH-1:0] a_raddr_i,
  output T                      a_dout_o,
  output logic                  a_dvalid_o,
  input  T                      b_din_i,
  input  logic                  b_wen_i,
  input  logic [ADDR_WIDTH-1:0] b_waddr_i,
  input  logic                  b_ren_i,
  input  logic [ADDR_WIDTH-1:0] b_raddr_i,
  output T                      b_dout_o,
  output logic                  b_dvalid_o,
  output logic                  wr_collision_o
);
  typedef enum logic {INIT, READY} state_e;
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(WORDS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return {1'b0, addr} < DEPTH;
  endfunction
  state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic a_we, b_we, a_re, b_re;
  T mem [WORDS];
  T a_rdata, b_rdata;
  T a_d1_q, b_d1_q, a_d2_q, b_d2_q;
  logic a_v1_q, b_v1_q, a_v2_q, b_v2_q, coll_q;
  // state register and clear pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
    end
  end
  // clear walks every word once, then waits in READY for a re-init request
  always_comb begin
    state_d = state_q == INIT ? (ptr_q == LAST_ADDR ? READY : INIT) : (init_req_i ? INIT : READY);
    ptr_d = state_q == INIT ? ptr_q + 1'b1 : '0;
  end
  // user accesses are gated off while the clear sequence owns the array
  always_comb begin
    init_busy_o = state_q == INIT;
    a_we = !init_busy_o && a_wen_i && in_range(a_waddr_i);
    b_we = !init_busy_o && b_wen_i && in_range(b_waddr_i);
    a_re = !init_busy_o && a_ren_i;
    b_re = !init_busy_o && b_ren_i;
  end
  // array writes; port A is applied last so it wins a same-address collision
  always_ff @(posedge clk) begin
    if (init_busy_o) mem[ptr_q] <= INIT_VALUE;
    if (b_we) mem[b_waddr_i] <= b_din_i;
    if (a_we) mem[a_waddr_i] <= a_din_i;
  end
  // read data with optional forwarding of same-cycle writes, A taking priority
  always_comb begin
    a_rdata = !in_range(a_raddr_i) ? T'('0) :
              WRITE_FIRST && a_we && a_waddr_i == a_raddr_i ? a_din_i :
              WRITE_FIRST && b_we && b_waddr_i == a_raddr_i ? b_din_i : mem[a_raddr_i];
    b_rdata = !in_range(b_raddr_i) ? T'('0) :
              WRITE_FIRST && a_we && a_waddr_i == b_raddr_i ? a_din_i :
              WRITE_FIRST && b_we && b_waddr_i == b_raddr_i ? b_din_i : mem[b_raddr_i];
  end
  // first read stage and collision flag; data holds when no read completes
  always_ff @(posedge clk) begin
    if (rst) begin
      a_d1_q <= '0;
      b_d1_q <= '0;
      a_v1_q <= 1'b0;
      b_v1_q <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      a_v1_q <= a_re;
      b_v1_q <= b_re;
      a_d1_q <= a_re ? a_rdata : a_d1_q;
      b_d1_q <= b_re ? b_rdata : b_d1_q;
      coll_q <= a_we && b_we && a_waddr_i == b_waddr_i;
    end
  end
  // optional output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      a_d2_q <= '0;
      b_d2_q <= '0;
      a_v2_q <= 1'b0;
      b_v2_q <= 1'b0;
    end else begin
      a_v2_q <= a_v1_q;
      b_v2_q <= b_v1_q;
      a_d2_q <= a_v1_q ? a_d1_q : a_d2_q;
      b_d2_q <= b_v1_q ? b_d1_q : b_d2_q;
    end
  end
  assign a_dout_o = OUT_REG ? a_d2_q : a_d1_q;
  assign b_dout_o = OUT_REG ? b_d2_q : b_d1_q;
  assign a_dvalid_o = OUT_REG ? a_v2_q : a_v1_q;
  assign b_dvalid_o = OUT_REG ? b_v2_q : b_v1_q;
  assign wr_collision_o = coll_q;
endmodule

// File: tb/tb_apd04_dpsram_init.sv
// tb_apd04_dpsram_init: scoreboard bench driving two configurations (128/read-first/1-cycle, 100/write-first/2-cycle) in lockstep
module tb_apd04_dpsram_init;
  typedef struct {int due; logic [31:0] v;} exp_t;
  logic clk = 0, rst = 1, init_req = 0;
  logic [31:0] a_din = 0, b_din = 0;
  logic a_wen = 0, b_wen = 0, a_ren = 0, b_ren = 0;
  logic [6:0] a_waddr = 0, b_waddr = 0, a_raddr = 0, b_raddr = 0;
  logic [3:0][31:0] dout;
  logic [3:0] dv;
  logic [1:0] busy, coll;
  logic [31:0] m [2][128];
  int cnt [2];
  logic cexp [2];
  logic [31:0] last [4];
  exp_t q [4][$];
  int cyc = 0, checks = 0, errors = 0;

  always #5 clk = ~clk;

  apd04_dpsram_init #(.WORDS(128)) dut0 (
    .clk(clk), .rst(rst), .init_req_i(init_req), .init_busy_o(busy[0]),
    .a_din_i(a_din), .a_wen_i(a_wen), .a_waddr_i(a_waddr), .a_ren_i(a_ren), .a_raddr_i(a_raddr),
    .a_dout_o(dout[0]), .a_dvalid_o(dv[0]),
    .b_din_i(b_din), .b_wen_i(b_wen), .b_waddr_i(b_waddr), .b_ren_i(b_ren), .b_raddr_i(b_raddr),
    .b_dout_o(dout[1]), .b_dvalid_o(dv[1]), .wr_collision_o(coll[0]));

  apd04_dpsram_init #(.WORDS(100), .OUT_REG(1'b1), .WRITE_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst), .init_req_i(init_req), .init_busy_o(busy[1]),
    .a_din_i(a_din), .a_wen_i(a_wen), .a_waddr_i(a_waddr), .a_ren_i(a_ren), .a_raddr_i(a_raddr),
    .a_dout_o(dout[2]), .a_dvalid_o(dv[2]),
    .b_din_i(b_din), .b_wen_i(b_wen), .b_waddr_i(b_waddr), .b_ren_i(b_ren), .b_raddr_i(b_raddr),
    .b_dout_o(dout[3]), .b_dvalid_o(dv[3]), .wr_collision_o(coll[1]));

  function automatic int words(int k);
    return k == 1 ? 100 : 128;
  endfunction

  function automatic logic [31:0] rd(int k, logic [6:0] ad);
    if (int'(ad) >= words(k)) return 32'h0;
    if (k == 1 && a_wen && a_waddr == ad) return a_din;
    if (k == 1 && b_wen && b_waddr == ad) return b_din;
    return m[k][ad];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        cnt[k] = words(k);
        cexp[k] = 1'b0;
        for (int p = 0; p < 2; p++) begin
          q[2*k+p].delete();
          last[2*k+p] = 32'h0;
        end
      end else if (cnt[k] > 0) begin
        cnt[k]--;
        cexp[k] = 1'b0;
        if (cnt[k] == 0) for (int i = 0; i < 128; i++) m[k][i] = '1;
      end else begin
        if (a_ren) q[2*k].push_back(exp_t'{cyc + k, rd(k, a_raddr)});
        if (b_ren) q[2*k+1].push_back(exp_t'{cyc + k, rd(k, b_raddr)});
        cexp[k] = a_wen && b_wen && a_waddr == b_waddr && int'(a_waddr) < words(k);
        if (b_wen && int'(b_waddr) < words(k)) m[k][b_waddr] = b_din;
        if (a_wen && int'(a_waddr) < words(k)) m[k][a_waddr] = a_din;
        if (init_req) cnt[k] = words(k);
      end
    end
  endtask

  task automatic monitor();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(cnt[k] > 0));
      chk($sformatf("coll%0d", k), 32'(coll[k]), 32'(cexp[k]));
    end
    for (int i = 0; i < 4; i++) begin
      if (q[i].size() > 0 && q[i][0].due == cyc) begin
        last[i] = q[i][0].v;
        void'(q[i].pop_front());
        chk($sformatf("dvalid%0d", i), 32'(dv[i]), 32'd1);
      end else begin
        chk($sformatf("dvalid%0d", i), 32'(dv[i]), 32'd0);
      end
      chk($sformatf("dout%0d", i), dout[i], last[i]);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      monitor();
      cyc++;
    end
  endtask

  task automatic idle();
    a_wen = 0; b_wen = 0; a_ren = 0; b_ren = 0; init_req = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    tick(3);
    rst = 0;
    for (int c = 0; c < 130; c++) begin
      a_ren = 1; a_raddr = 7'(c); b_ren = 1; b_raddr = 7'(127 - c);
      tick();
    end
    for (int c = 0; c < 128; c++) begin
      a_raddr = 7'(c); b_raddr = 7'(127 - c);
      tick();
    end
    idle(); tick(2);
    a_wen = 1; a_waddr = 5; a_din = 32'h11; b_wen = 1; b_waddr = 5; b_din = 32'h22;
    tick();
    idle(); a_ren = 1; a_raddr = 5; b_ren = 1; b_raddr = 5;
    tick();
    idle(); tick(2);
    a_wen = 1; a_waddr = 3; a_din = 32'hA;
    tick();
    a_din = 32'hB; b_ren = 1; b_raddr = 3;
    tick();
    idle(); a_ren = 1; a_raddr = 3; b_ren = 1; b_raddr = 3;
    tick();
    idle(); tick(2);
    for (int i = 0; i < 8; i++) begin
      a_wen = 1; a_waddr = 7'(i); a_din = 32'h100 + i;
      tick();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      a_ren = 1; a_raddr = 7'(i); b_ren = 1; b_raddr = 7'(7 - i);
      tick();
    end
    idle(); tick(3);
    a_wen = 1; a_waddr = 120; a_din = 32'h55; b_wen = 1; b_waddr = 99; b_din = 32'h99;
    tick();
    idle(); a_ren = 1; a_raddr = 120; b_ren = 1; b_raddr = 99;
    tick();
    idle(); tick(2);
    a_wen = 1; a_waddr = 9; a_din = 32'h7;
    tick();
    idle(); a_ren = 1; a_raddr = 9; init_req = 1;
    tick();
    for (int c = 0; c < 135; c++) begin
      init_req = c == 40; a_wen = c < 90; a_waddr = 9; a_din = 32'h8;
      a_ren = 1; a_raddr = 9; b_ren = 1; b_raddr = 7'(c);
      tick();
    end
    idle(); init_req = 1;
    tick();
    idle(); a_ren = 1;
    for (int c = 0; c < 50; c++) begin a_raddr = 7'(c); tick(); end
    rst = 1;
    tick();
    rst = 0;
    for (int c = 0; c < 140; c++) begin a_raddr = 7'(c); tick(); end
    idle();
    for (int c = 0; c < 400; c++) begin
      a_wen = 1'($urandom); b_wen = 1'($urandom); a_ren = 1'($urandom); b_ren = 1'($urandom);
      a_waddr = ($urandom % 8 == 0) ? 7'($urandom_range(96, 127)) : 7'($urandom_range(0, 7));
      b_waddr = ($urandom % 8 == 0) ? 7'($urandom_range(96, 127)) : 7'($urandom_range(0, 7));
      a_raddr = ($urandom % 8 == 0) ? 7'($urandom_range(96, 127)) : 7'($urandom_range(0, 7));
      b_raddr = ($urandom % 8 == 0) ? 7'($urandom_range(96, 127)) : 7'($urandom_range(0, 7));
      a_din = $urandom; b_din = $urandom;
      init_req = $urandom % 150 == 0;
      tick();
    end
    idle(); tick(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
